piece_collision_checker: RTL and testbench

Sequential legality checker that sits directly downstream of the block-shape decoder. It takes the decoder's four 4-bit piece rows plus a candidate board position and scans the matching rows of the 10x20 playfield RAM. It reports whether the piece overlaps a filled cell or leaves the board. The game controller runs it before every move, rotation and drop, and commits the move only when the check returns clear.

---
 rtl/piece_collision_checker.sv | 220 ++++++++++++++++++++++
 tb/tb_piece_collision_checker.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/piece_collision_checker.sv
// piece_collision_checker
// Checks whether a 4x4 piece at (pos_x, pos_y) overlaps a filled playfield
// cell or leaves the board. It reads one board row per cycle and evaluates
// each row one cycle after its read.
//
// Handshake: start is accepted only when busy=0. Accepting it latches the
// piece and position and clears collide. done pulses for one cycle, with
// collide valid in that cycle. start while busy=1 is dropped.
//
// Optional feature: define COLLISION_EARLY_EXIT_EN to end the check at the
// first evaluation that finds a collision. Without it, all four row slots
// always run and the latency is fixed at 5 cycles.
//
// dbg_state exposes the FSM state so checkers can bind to it.
module piece_collision_checker #(
    parameter int BOARD_W = 10,
    parameter int BOARD_H = 20
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [4:0]         pos_x,
    input  logic [5:0]         pos_y,
    input  logic [3:0]         pixels0,
    input  logic [3:0]         pixels1,
    input  logic [3:0]         pixels2,
    input  logic [3:0]         pixels3,
    output logic               rd_en,
    output logic [4:0]         rd_addr,
    input  logic [BOARD_W-1:0] rd_data,
    output logic               busy,
    output logic               done,
    output logic               collide,
    output logic [1:0]         dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SCAN  = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    // Board limits, expressed in the same 7-bit signed space as rows and columns.
    localparam logic signed [6:0] ROW_LIM = 7'(BOARD_H);
    localparam logic signed [6:0] COL_LIM = 7'(BOARD_W);

    state_t            state_q, state_d;
    logic [1:0]        slot_q, slot_d;
    logic              rd_en_q, rd_en_d;
    logic [4:0]        rd_addr_q, rd_addr_d;
    logic              done_q, done_d;
    logic              collide_q, collide_d;
    logic              load;

    logic [4:0]        px_q;
    logic [5:0]        py_q;
    logic [3:0]        pix_q [4];

    logic signed [6:0] px_s, py_s;
    logic signed [6:0] iss_row;
    logic              iss_ok;
    logic [1:0]        ev_idx;
    logic signed [6:0] ev_row;
    logic [3:0]        ev_mask;
    logic signed [6:0] col_s [4];
    logic [3:0]        occ;
    logic              ev_hit;
    logic              ev_valid;
    logic              ev_fire;

    assign px_s = {{2{px_q[4]}}, px_q};
    assign py_s = {py_q[5], py_q};

    // Row for the slot issued at the next edge: slot 0 comes straight from
    // the inputs on an accepted start; later slots use the latched position.
    always_comb begin
        if (state_q == S_IDLE) begin
            iss_row = $signed({pos_y[5], pos_y});
        end else begin
            iss_row = py_s + $signed({5'b0, slot_q + 2'd1});
        end
        iss_ok = (iss_row >= 7'sd0) && (iss_row < ROW_LIM);
    end

    // The slot under evaluation is the one read in the previous cycle.
    assign ev_idx   = (state_q == S_FLUSH) ? 2'd3 : (slot_q - 2'd1);
    assign ev_valid = (state_q == S_FLUSH) || ((state_q == S_SCAN) && (slot_q != 2'd0));

    // Column of each piece bit, and whether the returned board row is filled there.
    always_comb begin
        for (int b = 0; b < 4; b++) begin
            col_s[b] = px_s + 7'(3 - b);
            occ[b]   = 1'b0;
            for (int c = 0; c < BOARD_W; c++) begin
                if (col_s[b] == 7'(c)) begin
                    occ[b] = rd_data[c];
                end
            end
        end
    end

    // Collision test for one piece row: out of the side walls, below the
    // floor, or on a filled cell. Rows above the top only check the walls.
    always_comb begin
        ev_row  = py_s + $signed({5'b0, ev_idx});
        ev_mask = pix_q[ev_idx];
        ev_hit  = 1'b0;
        for (int b = 0; b < 4; b++) begin
            if (ev_mask[b]) begin
                if ((col_s[b] < 7'sd0) || (col_s[b] >= COL_LIM)) begin
                    ev_hit = 1'b1;
                end else if (ev_row >= ROW_LIM) begin
                    ev_hit = 1'b1;
                end else if ((ev_row >= 7'sd0) && occ[b]) begin
                    ev_hit = 1'b1;
                end
            end
        end
    end

    assign ev_fire = ev_valid && ev_hit;

    // FSM next state, read issue and result accumulation.
    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        rd_en_d   = 1'b0;
        rd_addr_d = rd_addr_q;
        done_d    = 1'b0;
        collide_d = collide_q;
        load      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    collide_d = 1'b0;
                    state_d   = S_SCAN;
                    slot_d    = 2'd0;
                    rd_en_d   = iss_ok;
                    if (iss_ok) begin
                        rd_addr_d = iss_row[4:0];
                    end
                end
            end
            S_SCAN: begin
                if (ev_fire) begin
                    collide_d = 1'b1;
                end
                if (slot_q == 2'd3) begin
                    state_d = S_FLUSH;
                end else begin
                    slot_d  = slot_q + 2'd1;
                    rd_en_d = iss_ok;
                    if (iss_ok) begin
                        rd_addr_d = iss_row[4:0];
                    end
                end
`ifdef COLLISION_EARLY_EXIT_EN
                // Stop at the first hit; any read still in flight is dropped.
                if (ev_fire) begin
                    state_d   = S_IDLE;
                    done_d    = 1'b1;
                    rd_en_d   = 1'b0;
                    rd_addr_d = rd_addr_q;
                end
`endif
            end
            S_FLUSH: begin
                if (ev_fire) begin
                    collide_d = 1'b1;
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, outputs and latched request registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            slot_q    <= 2'd0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= 5'd0;
            done_q    <= 1'b0;
            collide_q <= 1'b0;
            px_q      <= 5'd0;
            py_q      <= 6'd0;
            for (int i = 0; i < 4; i++) begin
                pix_q[i] <= 4'd0;
            end
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            done_q    <= done_d;
            collide_q <= collide_d;
            if (load) begin
                px_q     <= pos_x;
                py_q     <= pos_y;
                pix_q[0] <= pixels0;
                pix_q[1] <= pixels1;
                pix_q[2] <= pixels2;
                pix_q[3] <= pixels3;
            end
        end
    end

    assign rd_en     = rd_en_q;
    assign rd_addr   = rd_addr_q;
    assign done      = done_q;
    assign collide   = collide_q;
    assign busy      = (state_q != S_IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_piece_collision_checker.sv
// Directed testbench for piece_collision_checker. A small board RAM model
// returns the addressed row one cycle after rd_en. Expected values are
// hand-computed from the piece geometry.
module tb_piece_collision_checker;

`ifdef COLLISION_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       start;
    logic [4:0] pos_x;
    logic [5:0] pos_y;
    logic [3:0] pixels0, pixels1, pixels2, pixels3;
    logic       rd_en;
    logic [4:0] rd_addr;
    logic [9:0] rd_data;
    logic       busy;
    logic       done;
    logic       collide;
    logic [1:0] dbg_state;

    logic [9:0] board [32];

    int n_checks;
    int n_pass;

    // Observations from the most recent run_check
    int         obs_done_cyc;
    logic       obs_coll;
    logic [3:0] obs_en;
    logic [4:0] obs_addr [4];
    logic [5:0] obs_busy;

    piece_collision_checker #(.BOARD_W(10), .BOARD_H(20)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .pos_x    (pos_x),
        .pos_y    (pos_y),
        .pixels0  (pixels0),
        .pixels1  (pixels1),
        .pixels2  (pixels2),
        .pixels3  (pixels3),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .busy     (busy),
        .done     (done),
        .collide  (collide),
        .dbg_state(dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Board RAM model: one-cycle read latency
    always @(posedge clk or posedge rst) begin
        if (rst) rd_data <= 10'd0;
        else if (rd_en) rd_data <= board[rd_addr];
    end

    // Absolute time bound
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic clear_board();
        for (int i = 0; i < 32; i++) board[i] = 10'd0;
    endtask

    // Launch one check and record rd_en/rd_addr per slot, busy per cycle,
    // the done cycle and collide. Inputs are scrambled and start is held
    // high while busy to show both are ignored once a check is running.
    task automatic run_check(input bit no_wait, input logic [4:0] px, input logic [5:0] py,
                             input logic [3:0] p0, input logic [3:0] p1,
                             input logic [3:0] p2, input logic [3:0] p3);
        if (!no_wait) @(negedge clk);
        pos_x = px; pos_y = py;
        pixels0 = p0; pixels1 = p1; pixels2 = p2; pixels3 = p3;
        start = 1'b1;
        @(posedge clk);
        #1;
        pos_x = 5'd7; pos_y = 6'd0;
        pixels0 = 4'hF; pixels1 = 4'hF; pixels2 = 4'hF; pixels3 = 4'hF;
        obs_done_cyc = -1;
        obs_coll = 1'b0;
        obs_en = 4'b0;
        obs_busy = 6'b0;
        for (int i = 0; i < 4; i++) obs_addr[i] = 5'd0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (c < 4) begin
                obs_en[c] = rd_en;
                obs_addr[c] = rd_addr;
            end
            if (c < 6) obs_busy[c] = busy;
            if (done) begin
                obs_done_cyc = c;
                obs_coll = collide;
                break;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (rd_en !== 1'b0) $display("FAIL reset_rd_en: got %b expected 0", rd_en); else n_pass++;
        n_checks++; if (rd_addr !== 5'd0) $display("FAIL reset_rd_addr: got %0d expected 0", rd_addr); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else n_pass++;
        n_checks++; if (collide !== 1'b0) $display("FAIL reset_collide: got %b expected 0", collide); else n_pass++;
        n_checks++; if (dbg_state !== 2'd0) $display("FAIL reset_state: got %0d expected 0", dbg_state); else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        run_check(0, 5'd0, 6'd0, 4'b0111, 4'b0010, 4'b0000, 4'b0000);
        n_checks++; if (obs_done_cyc !== 5) $display("FAIL basic_done_cycle: got %0d expected 5", obs_done_cyc); else n_pass++;
        n_checks++; if (obs_coll !== 1'b0) $display("FAIL basic_collide: got %b expected 0", obs_coll); else n_pass++;
        n_checks++; if (obs_en !== 4'b1111) $display("FAIL basic_rd_en_slots: got %b expected 1111", obs_en); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (obs_addr[k] !== 5'(k)) $display("FAIL basic_rd_addr_slot%0d: got %0d expected %0d", k, obs_addr[k], k);
            else n_pass++;
        end
        n_checks++; if (obs_busy[4] !== 1'b1) $display("FAIL basic_busy_cycle4: got %b expected 1", obs_busy[4]); else n_pass++;
        n_checks++; if (obs_busy[5] !== 1'b0) $display("FAIL basic_busy_cycle5: got %b expected 0", obs_busy[5]); else n_pass++;
    endtask

    task automatic test_right_wall();
        // pixels0 lands on columns 8, 9, 10; column 10 is off the board.
        run_check(0, 5'd7, 6'd0, 4'b0111, 4'b0010, 4'b0000, 4'b0000);
        n_checks++; if (obs_coll !== 1'b1) $display("FAIL right_wall_collide: got %b expected 1", obs_coll); else n_pass++;
        n_checks++;
        if (obs_done_cyc !== (EARLY ? 2 : 5)) $display("FAIL right_wall_done_cycle: got %0d expected %0d", obs_done_cyc, EARLY ? 2 : 5);
        else n_pass++;
    endtask

    task automatic test_left_edge();
        // pos_x=-1: cells on columns 0..2 only.
        run_check(0, 5'b11111, 6'd0, 4'b0111, 4'b0010, 4'b0000, 4'b0000);
        n_checks++; if (obs_coll !== 1'b0) $display("FAIL left_edge_collide: got %b expected 0", obs_coll); else n_pass++;
        n_checks++; if (obs_done_cyc !== 5) $display("FAIL left_edge_done_cycle: got %0d expected 5", obs_done_cyc); else n_pass++;
    endtask

    task automatic test_floor();
        // pos_y=19: row 19 read, row 20 (pixels1) is below the floor.
        run_check(0, 5'd0, 6'd19, 4'b0111, 4'b0010, 4'b0000, 4'b0000);
        n_checks++; if (obs_coll !== 1'b1) $display("FAIL floor_collide: got %b expected 1", obs_coll); else n_pass++;
        n_checks++; if (obs_en !== 4'b0001) $display("FAIL floor_rd_en_slots: got %b expected 0001", obs_en); else n_pass++;
        n_checks++; if (obs_addr[0] !== 5'd19) $display("FAIL floor_rd_addr_slot0: got %0d expected 19", obs_addr[0]); else n_pass++;
        n_checks++; if (obs_addr[1] !== 5'd19) $display("FAIL floor_rd_addr_hold: got %0d expected 19", obs_addr[1]); else n_pass++;
        n_checks++;
        if (obs_done_cyc !== (EARLY ? 3 : 5)) $display("FAIL floor_done_cycle: got %0d expected %0d", obs_done_cyc, EARLY ? 3 : 5);
        else n_pass++;
    endtask

    task automatic test_overlap();
        // Board row 1 has column 2 filled; pixels1 lands on (col 2, row 1).
        board[1] = 10'b0000000100;
        run_check(0, 5'd0, 6'd0, 4'b0111, 4'b0010, 4'b0000, 4'b0000);
        n_checks++; if (obs_coll !== 1'b1) $display("FAIL overlap_collide: got %b expected 1", obs_coll); else n_pass++;
        n_checks++;
        if (obs_done_cyc !== (EARLY ? 3 : 5)) $display("FAIL overlap_done_cycle: got %0d expected %0d", obs_done_cyc, EARLY ? 3 : 5);
        else n_pass++;
        // Same board, piece shifted right by one: column 2 now only under pixels0 row 0.
        run_check(0, 5'd1, 6'd0, 4'b0111, 4'b0010, 4'b0000, 4'b0000);
        n_checks++; if (obs_coll !== 1'b0) $display("FAIL overlap_miss_collide: got %b expected 0", obs_coll); else n_pass++;
        clear_board();
    endtask

    task automatic test_spawn();
        // pos_y=-1: slot 0 is above the top and not read.
        run_check(0, 5'd3, 6'b111111, 4'b0111, 4'b0010, 4'b0000, 4'b0000);
        n_checks++; if (obs_coll !== 1'b0) $display("FAIL spawn_collide: got %b expected 0", obs_coll); else n_pass++;
        n_checks++; if (obs_en !== 4'b1110) $display("FAIL spawn_rd_en_slots: got %b expected 1110", obs_en); else n_pass++;
        n_checks++; if (obs_addr[1] !== 5'd0) $display("FAIL spawn_rd_addr_slot1: got %0d expected 0", obs_addr[1]); else n_pass++;
        n_checks++; if (obs_addr[3] !== 5'd2) $display("FAIL spawn_rd_addr_slot3: got %0d expected 2", obs_addr[3]); else n_pass++;
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        pos_x = 5'd7; pos_y = 6'd0;
        pixels0 = 4'b0111; pixels1 = 4'b0010; pixels2 = 4'b0000; pixels3 = 4'b0000;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        // Cycle 2: slot 0 already evaluated as a wall hit.
        n_checks++; if (collide !== 1'b1) $display("FAIL reset_mid_pre_collide: got %b expected 1", collide); else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++; if (rd_en !== 1'b0) $display("FAIL reset_mid_rd_en: got %b expected 0", rd_en); else n_pass++;
        n_checks++; if (rd_addr !== 5'd0) $display("FAIL reset_mid_rd_addr: got %0d expected 0", rd_addr); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_mid_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_mid_done: got %b expected 0", done); else n_pass++;
        n_checks++; if (collide !== 1'b0) $display("FAIL reset_mid_collide: got %b expected 0", collide); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        run_check(0, 5'd0, 6'd0, 4'b0111, 4'b0010, 4'b0000, 4'b0000);
        n_checks++; if (obs_done_cyc !== 5) $display("FAIL after_reset_done_cycle: got %0d expected 5", obs_done_cyc); else n_pass++;
        n_checks++; if (obs_coll !== 1'b0) $display("FAIL after_reset_collide: got %b expected 0", obs_coll); else n_pass++;
        n_checks++; if (obs_addr[2] !== 5'd2) $display("FAIL after_reset_rd_addr_slot2: got %0d expected 2", obs_addr[2]); else n_pass++;
    endtask

    task automatic test_back_to_back();
        run_check(0, 5'd0, 6'd0, 4'b0000, 4'b0000, 4'b0000, 4'b1111);
        n_checks++; if (obs_coll !== 1'b0) $display("FAIL b2b_first_collide: got %b expected 0", obs_coll); else n_pass++;
        // Next start driven during the done cycle, sampled at E6.
        run_check(1, 5'd7, 6'd0, 4'b0111, 4'b0010, 4'b0000, 4'b0000);
        n_checks++; if (obs_busy[0] !== 1'b1) $display("FAIL b2b_second_busy: got %b expected 1", obs_busy[0]); else n_pass++;
        n_checks++; if (obs_coll !== 1'b1) $display("FAIL b2b_second_collide: got %b expected 1", obs_coll); else n_pass++;
        n_checks++;
        if (obs_done_cyc !== (EARLY ? 2 : 5)) $display("FAIL b2b_second_done_cycle: got %0d expected %0d", obs_done_cyc, EARLY ? 2 : 5);
        else n_pass++;
        // A clean check right after a colliding one clears collide.
        run_check(1, 5'd6, 6'd10, 4'b1000, 4'b1000, 4'b1000, 4'b1000);
        n_checks++; if (obs_coll !== 1'b0) $display("FAIL b2b_third_collide: got %b expected 0", obs_coll); else n_pass++;
        n_checks++; if (obs_addr[3] !== 5'd13) $display("FAIL b2b_third_rd_addr_slot3: got %0d expected 13", obs_addr[3]); else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass = 0;
        rst = 1'b1;
        start = 1'b0;
        pos_x = 5'd0;
        pos_y = 6'd0;
        pixels0 = 4'd0; pixels1 = 4'd0; pixels2 = 4'd0; pixels3 = 4'd0;
        clear_board();

        test_reset();
        test_basic();
        test_right_wall();
        test_left_edge();
        test_floor();
        test_overlap();
        test_spawn();
        test_reset_mid();
        test_back_to_back();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
